// File: rtl/gray_pkg.sv
// Shared types and constants for the Gray-code decode monitor.
package gray_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  logic [WIDTH-1:0] w_bin;

  always_comb begin
    w_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_bin[i] = ^(i_gray >> i);
    end
  end

  assign o_bin = w_bin;

endmodule

// File: rtl/gray_decode_monitor.sv
// Decodes Gray samples, classifies each step against the previous value and tracks lock/fault.
// All outputs registered; one cycle from an accepted sample to B_OUT/B_VALID/DIR/ERR.
module gray_decode_monitor
  import gray_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int RESYNC_LEN = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] G_IN,
  input  logic             G_VALID,
  output logic [WIDTH-1:0] B_OUT,
  output logic             B_VALID,
  output logic [1:0]       DIR,
  output logic             ERR,
  output logic [7:0]       ERR_CNT,
  output logic             LOCKED
);

  localparam logic [3:0] LP_RESYNC = 4'(RESYNC_LEN);

  state_t           r_state,  w_state_nxt;
  logic [WIDTH-1:0] r_prev,   w_prev_nxt;
  logic [WIDTH-1:0] r_bout,   w_bout_nxt;
  logic             r_bvalid, w_bvalid_nxt;
  logic [1:0]       r_dir,    w_dir_nxt;
  logic             r_err,    w_err_nxt;
  logic [7:0]       r_errcnt, w_errcnt_nxt;
  logic [3:0]       r_resync, w_resync_nxt;

  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_diff;
  logic             w_legal;
  logic [1:0]       w_step_dir;
  logic [7:0]       w_errcnt_inc;

  gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
    .i_gray (G_IN),
    .o_bin  (w_bin)
  );

  // Modulo-2^WIDTH difference makes max->0 an up step and 0->max a down step.
  assign w_diff       = w_bin - r_prev;
  assign w_legal      = (w_diff == '0) || (w_diff == WIDTH'(1)) || (w_diff == '1);
  assign w_step_dir   = (w_diff == WIDTH'(1)) ? DIR_UP :
                        (w_diff == '1)        ? DIR_DOWN : DIR_HOLD;
  assign w_errcnt_inc = (r_errcnt == ERR_CNT_MAX) ? r_errcnt : r_errcnt + 8'd1;

  always_comb begin
    w_state_nxt  = r_state;
    w_prev_nxt   = r_prev;
    w_bout_nxt   = r_bout;
    w_bvalid_nxt = 1'b0;
    w_dir_nxt    = r_dir;
    w_err_nxt    = 1'b0;
    w_errcnt_nxt = r_errcnt;
    w_resync_nxt = r_resync;
    if (G_VALID) begin
      w_prev_nxt   = w_bin;
      w_bout_nxt   = w_bin;
      w_bvalid_nxt = 1'b1;
      case (r_state)
        ST_IDLE: begin
          w_dir_nxt    = DIR_HOLD;
          w_resync_nxt = 4'd0;
          w_state_nxt  = ST_TRACK;
        end
        ST_TRACK: begin
          if (w_legal) begin
            w_dir_nxt = w_step_dir;
          end else begin
            w_err_nxt    = 1'b1;
            w_errcnt_nxt = w_errcnt_inc;
            w_dir_nxt    = DIR_HOLD;
            w_resync_nxt = 4'd0;
            w_state_nxt  = ST_FAULT;
          end
        end
        ST_FAULT: begin
          if (w_legal) begin
            w_dir_nxt = w_step_dir;
            // Hold samples count toward resync just like up/down steps.
            if (r_resync + 4'd1 == LP_RESYNC) begin
              w_resync_nxt = 4'd0;
              w_state_nxt  = ST_TRACK;
            end else begin
              w_resync_nxt = r_resync + 4'd1;
            end
          end else begin
            w_err_nxt    = 1'b1;
            w_errcnt_nxt = w_errcnt_inc;
            w_dir_nxt    = DIR_HOLD;
            w_resync_nxt = 4'd0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= ST_IDLE;
      r_prev   <= '0;
      r_bout   <= '0;
      r_bvalid <= 1'b0;
      r_dir    <= DIR_HOLD;
      r_err    <= 1'b0;
      r_errcnt <= 8'd0;
      r_resync <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_prev   <= w_prev_nxt;
      r_bout   <= w_bout_nxt;
      r_bvalid <= w_bvalid_nxt;
      r_dir    <= w_dir_nxt;
      r_err    <= w_err_nxt;
      r_errcnt <= w_errcnt_nxt;
      r_resync <= w_resync_nxt;
    end
  end

  assign B_OUT   = r_bout;
  assign B_VALID = r_bvalid;
  assign DIR     = r_dir;
  assign ERR     = r_err;
  assign ERR_CNT = r_errcnt;
  assign LOCKED  = (r_state == ST_TRACK);

endmodule

// File: tb/tb_gray_decode_monitor.sv
// Scoreboard bench: the driver pushes reference-model results, the monitor pops on B_VALID.
module tb_gray_decode_monitor;

  localparam int W    = 4;
  localparam int RLEN = 2;
  localparam int NVAL = 1 << W;

  typedef struct packed {
    logic [W-1:0] b;
    logic [1:0]   dir;
    logic         err;
    logic [7:0]   cnt;
    logic         locked;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] G_IN = '0;
  logic         G_VALID = 1'b0;
  logic [W-1:0] B_OUT;
  logic         B_VALID;
  logic [1:0]   DIR;
  logic         ERR;
  logic [7:0]   ERR_CNT;
  logic         LOCKED;

  logic clk_en = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t last = '0;

  // Reference model state: mode 0 = not yet seen a sample, 1 = locked, 2 = faulted.
  int m_mode = 0;
  int m_prev = 0;
  int m_cnt  = 0;
  int m_rs   = 0;
  int cur_b  = 0;

  gray_decode_monitor #(.WIDTH(W), .RESYNC_LEN(RLEN)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .G_IN    (G_IN),
    .G_VALID (G_VALID),
    .B_OUT   (B_OUT),
    .B_VALID (B_VALID),
    .DIR     (DIR),
    .ERR     (ERR),
    .ERR_CNT (ERR_CNT),
    .LOCKED  (LOCKED)
  );

  initial begin
    forever begin
      #5;
      if (clk_en) CLK = ~CLK;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic model(input logic [W-1:0] g);
    exp_t e;
    int   b, d;
    b = 0;
    for (int v = 0; v < NVAL; v++) if ((v ^ (v >> 1)) == int'(g)) b = v;
    d = (b - m_prev + NVAL) % NVAL;
    e.b   = W'(b);
    e.err = 1'b0;
    e.dir = (d == 1) ? 2'b01 : (d == NVAL - 1) ? 2'b10 : 2'b00;
    if (m_mode == 0) begin
      e.dir  = 2'b00;
      m_mode = 1;
    end else if (d == 0 || d == 1 || d == NVAL - 1) begin
      if (m_mode == 2) begin
        m_rs++;
        if (m_rs == RLEN) begin
          m_mode = 1;
          m_rs   = 0;
        end
      end
    end else begin
      e.err  = 1'b1;
      e.dir  = 2'b00;
      m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_rs   = 0;
      m_mode = 2;
    end
    m_prev   = b;
    e.cnt    = 8'(m_cnt);
    e.locked = (m_mode == 1);
    q.push_back(e);
  endtask

  task automatic send(input logic [W-1:0] g);
    @(negedge CLK);
    G_IN    = g;
    G_VALID = 1'b1;
    model(g);
  endtask

  task automatic send_bin(input int b);
    logic [W-1:0] g;
    g = W'(b ^ (b >> 1));
    send(g);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      G_VALID = 1'b0;
    end
  endtask

  // Stops the clock where it is, asserts reset and checks the outputs clear without an edge.
  task automatic do_reset(input string tag);
    clk_en  = 1'b0;
    G_VALID = 1'b0;
    RST     = 1'b0;
    #1;
    check({tag, "_b_out"},   32'(B_OUT),   32'd0);
    check({tag, "_b_valid"}, 32'(B_VALID), 32'd0);
    check({tag, "_dir"},     32'(DIR),     32'd0);
    check({tag, "_err"},     32'(ERR),     32'd0);
    check({tag, "_err_cnt"}, 32'(ERR_CNT), 32'd0);
    check({tag, "_locked"},  32'(LOCKED),  32'd0);
    m_mode = 0;
    m_prev = 0;
    m_cnt  = 0;
    m_rs   = 0;
    cur_b  = 0;
    #2;
    RST    = 1'b1;
    #2;
    clk_en = 1'b1;
  endtask

  always @(negedge CLK or negedge RST) begin
    exp_t e;
    if (!RST) begin
      q.delete();
      last = '0;
    end else if (B_VALID) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_b_valid: got B_OUT=%0d with no sample pending", B_OUT);
      end else begin
        e = q.pop_front();
        if ({B_OUT, DIR, ERR, ERR_CNT, LOCKED} !== {e.b, e.dir, e.err, e.cnt, e.locked}) begin
          n_fail++;
          $display("FAIL sample: got b=%0d dir=%0d err=%0b cnt=%0d lock=%0b expected b=%0d dir=%0d err=%0b cnt=%0d lock=%0b",
                   B_OUT, DIR, ERR, ERR_CNT, LOCKED, e.b, e.dir, e.err, e.cnt, e.locked);
        end
        last = e;
      end
    end else begin
      n_cmp++;
      if ({ERR, B_OUT, DIR, ERR_CNT, LOCKED} !== {1'b0, last.b, last.dir, last.cnt, last.locked}) begin
        n_fail++;
        $display("FAIL held: got err=%0b b=%0d dir=%0d cnt=%0d lock=%0b expected err=0 b=%0d dir=%0d cnt=%0d lock=%0b",
                 ERR, B_OUT, DIR, ERR_CNT, LOCKED, last.b, last.dir, last.cnt, last.locked);
      end
    end
  end

  initial begin
    int b;
    int waited;
    logic [W-1:0] g;

    do_reset("rst0");

    // Down count after reset.
    send(4'b1000); send(4'b1001); send(4'b1011); send(4'b1010);
    idle(3);

    // Wrap in both directions.
    do_reset("rst1");
    send(4'b0000); send(4'b1000); send(4'b1000); send(4'b0000);
    idle(3);

    // Illegal +2 step, then resync through an interleaved fault.
    do_reset("rst2");
    send(4'b0111); send(4'b0110); send(4'b0101);
    send(4'b0100); send(4'b0000); send(4'b0001); send(4'b0011);
    idle(3);

    // Randomised walk with G_VALID gaps and occasional jumps.
    for (int i = 0; i < 400; i++) begin
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 9) < 8) b = (cur_b + int'($urandom_range(0, 2)) - 1 + NVAL) % NVAL;
      else b = int'($urandom_range(0, NVAL - 1));
      cur_b = b;
      send_bin(b);
    end
    idle(3);

    // Saturation: alternate 0 and 8 so every step is illegal.
    for (int i = 0; i < 300; i++) send_bin((i % 2) * 8);
    send_bin(0);
    @(posedge CLK);
    #1;
    clk_en = 1'b0;
    check("sat_err_cnt", 32'(ERR_CNT), 32'd255);
    check("sat_err_pulse", 32'(ERR), 32'd1);
    do_reset("rst_mid");

    send(4'b0011); send(4'b0010);
    idle(1);

    waited = 0;
    while (q.size() != 0 && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_decode_monitor.md
GRAY_DECODE_MONITOR -- requirements
Module: gray_decode_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 4: Gray/binary word width, legal range 2..8.
REQ-002 SHALL have parameter RESYNC_LEN, default 2: number of consecutive legal samples needed to leave FAULT, legal range 1..15.
REQ-003 SHALL have port CLK  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port G_IN  input  WIDTH  Gray-coded sample from the counter.
REQ-006 SHALL have port G_VALID  input  1  G_IN is valid this cycle.
REQ-007 SHALL have port B_OUT  output  WIDTH  registered binary decode of the last accepted sample.
REQ-008 SHALL have port B_VALID  output  1  one-cycle pulse marking a new B_OUT.
REQ-009 SHALL have port DIR  output  2  last step direction: 00 hold/none, 01 up, 10 down; 11 is never driven.
REQ-010 SHALL have port ERR  output  1  one-cycle pulse on an illegal step.
REQ-011 SHALL have port ERR_CNT  output  8  saturating count of illegal steps.
REQ-012 SHALL have port LOCKED  output  1  high while the state is TRACK.

Function
REQ-013 SHALL decode Gray to binary MSB-first: B[WIDTH-1]=G[WIDTH-1]; B[i]=B[i+1]^G[i].
REQ-014 SHALL register B_OUT and B_VALID exactly 1 cycle after the G_VALID cycle; B_VALID SHALL be 0 in cycles with no accepted sample.
REQ-015 SHALL hold B_OUT, DIR and the state unchanged when G_VALID=0.
REQ-016 SHALL classify each accepted sample against the previous accepted binary value P, modulo 2^WIDTH: B=P+1 up, B=P-1 down, B=P hold, anything else illegal.
REQ-017 SHALL treat wrap-around as legal: P=max to 0 is up, and P=0 to max is down.
REQ-018 SHALL implement FSM states IDLE, TRACK and FAULT.
REQ-019 In IDLE, the first accepted sample SHALL update P, set DIR=00, raise no ERR, and move the state to TRACK.
REQ-020 In TRACK, a legal sample SHALL update P and DIR; an illegal sample SHALL pulse ERR, increment ERR_CNT, update P, set DIR=00, and move the state to FAULT.
REQ-021 In FAULT, each legal sample SHALL increment a resync counter and each illegal sample SHALL pulse ERR, increment ERR_CNT and clear the resync counter.
REQ-022 In FAULT, the state SHALL move to TRACK on the sample that brings the resync counter to RESYNC_LEN, and DIR SHALL update on legal samples.
REQ-023 ERR_CNT SHALL saturate at 255; ERR SHALL still pulse on illegal steps while ERR_CNT is saturated.
REQ-024 ERR, B_VALID and the new DIR SHALL all appear in the same cycle as the B_OUT update.
REQ-025 A hold sample (B=P) SHALL count as legal for resync.

Reset
REQ-026 On RST low, outputs SHALL be B_OUT=0, B_VALID=0, DIR=00, ERR=0, ERR_CNT=0 and LOCKED=0, and internal state SHALL be state=IDLE, P=0, resync counter=0.
REQ-027 Reset asserted mid-operation SHALL take effect immediately, regardless of CLK.
REQ-028 The first accepted sample after reset release SHALL be handled as the IDLE first sample.

Structure
REQ-029 A shared package gray_pkg SHALL hold the FSM state type, the DIR encodings (DIR_HOLD, DIR_UP, DIR_DOWN) and the ERR_CNT saturation constant.
REQ-030 The design SHALL contain one combinational sub-module gray_to_bin, parameterised by WIDTH, instantiated once.
REQ-031 The remaining logic (previous-value register, step classifier, FSM, counters) SHALL live in gray_decode_monitor.

Verification
REQ-032 Reset, then down-count samples G_IN=1000,1001,1011,1010 at WIDTH=4 -> B_OUT=15,14,13,12; DIR=00, 10, 10, 10; LOCKED=1 after the first sample; ERR never asserted.
REQ-033 Wrap test: G_IN=0000 followed by 1000 -> second result B_OUT=15, DIR=10; G_IN=1000 followed by 0000 -> second result B_OUT=0, DIR=01; ERR=0 throughout.
REQ-034 Illegal step: in TRACK with B_OUT=5, apply G_IN=0110 (binary 4, legal down), then 0101 (binary 6, illegal jump of +2) -> ERR pulse, ERR_CNT=1, LOCKED=0, DIR=00.
REQ-035 Resync: in FAULT with RESYNC_LEN=2, apply a legal sample, an illegal sample, then two legal samples -> ERR_CNT increments on the illegal sample, and LOCKED=1 only after the final legal sample.
REQ-036 Saturation and reset: drive 300 alternating illegal samples -> ERR_CNT=255 with ERR still pulsing; then assert RST mid-stream with CLK held -> all outputs 0 immediately.
REQ-037 G_VALID gaps: interleave idle cycles between samples -> B_VALID pulses only on accepted samples, and outputs are held during the gaps.
